rom_seq_reader: RTL

- Sequencer that sits directly upstream of the 8-entry x 14-bit combinational text ROM (ROM_BHL) and drives that ROM's address.
- On a start pulse it walks the ROM from address 0 to LAST_ADDR, registering each word.
- Each registered word is presented on a valid/ready stream, together with its address, to the downstream display/serialiser stage.
- Replaces the testbench-style address loop with synthesizable, back-pressure-aware control.

---
 rtl/rom_seq_reader_if.sv | 31 +++
 rtl/rom_seq_reader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rom_seq_reader_if.sv
// Bundle between the scan sequencer, the text ROM it addresses, and the downstream
// word stream. The master side is the sequencer.
interface rom_seq_reader_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 14
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;

    modport master (
        output rom_addr,
        input  rom_dout,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_addr
    );

    modport slave (
        input  rom_addr,
        output rom_dout,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_addr
    );
endinterface

// File: rtl/rom_seq_reader.sv
// Walks a combinational ROM from address 0 to LAST_ADDR on a start pulse and streams
// each registered word, tagged with its address, over a valid/ready handshake.
module rom_seq_reader #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned LAST_ADDR = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    rom_seq_reader_if.master       bus,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs_c;
    logic              last_c;

    assign hs_c   = m_valid_q & bus.m_ready;
    assign last_c = (rom_addr_q == LAST);

    // State and output registers; rst outranks everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            m_addr_q   <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            m_addr_q   <= m_addr_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; abort preempts both the handshake and a new start.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        m_addr_d   = m_addr_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            m_valid_d  = 1'b0;
            rom_addr_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rom_addr_d = '0;
                    if (start) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    m_data_d  = bus.rom_dout;
                    m_addr_d  = rom_addr_q;
                    m_valid_d = 1'b1;
                    state_d   = SEND;
                end
                SEND: begin
                    if (hs_c) begin
                        m_valid_d = 1'b0;
                        if (last_c) begin
                            rom_addr_d = '0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            rom_addr_d = rom_addr_q + ONE;
                            state_d    = FETCH;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    m_valid_d  = 1'b0;
                    rom_addr_d = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_addr   = m_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // A presented word must stay put until taken, barring abort.
    a_hold_until_hs: assert property (@(posedge clk) disable iff (rst)
        (m_valid_q && !bus.m_ready && !abort)
            |=> (m_valid_q && $stable(m_data_q) && $stable(m_addr_q)));

    a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
        rom_addr_q <= LAST);

endmodule
